// File: rtl/hazard_ctrl_pkg.sv
// Purpose: shared pipeline encodings (Tuse, Tnew, ID forward selects) and the register match rule.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    typedef logic [4:0] reg_idx_t;
    typedef logic [1:0] tuse_t;
    typedef logic [1:0] tnew_t;
    typedef logic [1:0] fwd_sel_t;

    // Cycles until the ID instruction consumes an operand.
    localparam tuse_t TUSE_ID   = 2'd0;
    localparam tuse_t TUSE_EX   = 2'd1;
    localparam tuse_t TUSE_NONE = 2'd3;

    // Cycles until a producer's result exists.
    localparam tnew_t TNEW_NOW = 2'd0;
    localparam tnew_t TNEW_ONE = 2'd1;
    localparam tnew_t TNEW_TWO = 2'd2;

    // ID-stage operand source.
    localparam fwd_sel_t FWD_RF  = 2'd0;
    localparam fwd_sel_t FWD_WB  = 2'd1;
    localparam fwd_sel_t FWD_MEM = 2'd2;

    // A stage supplies src only if it really writes a non-$0 register equal to src.
    function automatic logic reg_match(input logic we, input reg_idx_t rd, input reg_idx_t src);
        return we && (rd != 5'd0) && (rd == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Purpose: mult/div occupancy countdown; reports the unit busy while an op is issuing or in flight.
// Latency: md_busy follows md_start combinationally; the countdown part appears one edge after issue.
// Backpressure: none; an issue while the counter is running is ignored (upstream stall prevents it).
// Ports: clk, rst_n (async active-low), md_start/md_div (issue in EX, div select), md_busy (out).
module md_busy_timer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (md_start && (count_q == '0)) begin
            count_q <= md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (count_q != '0) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign md_busy = md_start | (count_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: pipeline stall/flush/forward controller using Tuse/Tnew plus mult/div busy tracking.
// Latency: stall, flush_ID_EX, fwd_* are 0-cycle combinational; stall_cnt updates on the edge.
// Backpressure: stall freezes PC/IF_ID and flush_ID_EX bubbles ID_EX in the same cycle.
// Ports: ID sources + Tuse, EX/MEM/WB destinations + write enables + Tnew, mult/div issue;
//        outputs stall, flush_ID_EX, md_busy, fwd_rs_ID/fwd_rt_ID, stall_cnt (saturating).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_IF_ID,
    input  logic [4:0]       rt_IF_ID,
    input  logic [1:0]       tuse_rs_ID,
    input  logic [1:0]       tuse_rt_ID,
    input  logic             md_use_ID,
    input  logic [4:0]       rd_ID_EX,
    input  logic             we_ID_EX,
    input  logic [1:0]       tnew_ID_EX,
    input  logic [4:0]       rd_EX_MEM,
    input  logic             we_EX_MEM,
    input  logic [1:0]       tnew_EX_MEM,
    input  logic [4:0]       rd_MEM_WB,
    input  logic             we_MEM_WB,
    input  logic             md_start_ID_EX,
    input  logic             md_div_ID_EX,
    output logic             stall,
    output logic             flush_ID_EX,
    output logic             md_busy,
    output logic [1:0]       fwd_rs_ID,
    output logic [1:0]       fwd_rt_ID,
    output logic [CNT_W-1:0] stall_cnt
);

    logic rs_stall;
    logic rt_stall;
    logic md_stall;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (md_start_ID_EX),
        .md_div   (md_div_ID_EX),
        .md_busy  (md_busy)
    );

    // A source stalls when a matching producer's result arrives later than the consumer needs it.
    function automatic logic src_stall(input reg_idx_t src, input tuse_t tuse,
                                       input reg_idx_t rd_ex, input logic we_ex, input tnew_t tnew_ex,
                                       input reg_idx_t rd_mem, input logic we_mem, input tnew_t tnew_mem);
        logic hit_ex;
        logic hit_mem;
        hit_ex  = reg_match(we_ex, rd_ex, src) && (tnew_ex > tuse);
        hit_mem = reg_match(we_mem, rd_mem, src) && (tnew_mem > tuse);
        return (tuse != TUSE_NONE) && (hit_ex || hit_mem);
    endfunction

    // The younger producer (MEM) takes priority over WB when both hold the register.
    function automatic fwd_sel_t src_fwd(input reg_idx_t src,
                                         input reg_idx_t rd_mem, input logic we_mem, input tnew_t tnew_mem,
                                         input reg_idx_t rd_wb, input logic we_wb);
        if (reg_match(we_mem, rd_mem, src) && (tnew_mem == TNEW_NOW)) begin
            return FWD_MEM;
        end else if (reg_match(we_wb, rd_wb, src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        rs_stall  = src_stall(rs_IF_ID, tuse_rs_ID, rd_ID_EX, we_ID_EX, tnew_ID_EX,
                              rd_EX_MEM, we_EX_MEM, tnew_EX_MEM);
        rt_stall  = src_stall(rt_IF_ID, tuse_rt_ID, rd_ID_EX, we_ID_EX, tnew_ID_EX,
                              rd_EX_MEM, we_EX_MEM, tnew_EX_MEM);
        md_stall  = md_use_ID & md_busy;
        fwd_rs_ID = src_fwd(rs_IF_ID, rd_EX_MEM, we_EX_MEM, tnew_EX_MEM, rd_MEM_WB, we_MEM_WB);
        fwd_rt_ID = src_fwd(rt_IF_ID, rd_EX_MEM, we_EX_MEM, tnew_EX_MEM, rd_MEM_WB, we_MEM_WB);
    end

    assign stall       = rs_stall | rt_stall | md_stall;
    assign flush_ID_EX = stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: self-checking bench for hazard_ctrl against a cycle-number based reference model.
// Latency: checks combinational outputs each cycle at the falling edge, plus directed literals.
// Backpressure: n/a.
module tb_hazard_ctrl;

    localparam int MC   = 5;
    localparam int DC   = 10;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [4:0]    rs_IF_ID, rt_IF_ID;
    logic [1:0]    tuse_rs_ID, tuse_rt_ID;
    logic          md_use_ID;
    logic [4:0]    rd_ID_EX, rd_EX_MEM, rd_MEM_WB;
    logic          we_ID_EX, we_EX_MEM, we_MEM_WB;
    logic [1:0]    tnew_ID_EX, tnew_EX_MEM;
    logic          md_start_ID_EX, md_div_ID_EX;
    logic          stall, flush_ID_EX, md_busy;
    logic [1:0]    fwd_rs_ID, fwd_rt_ID;
    logic [CW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rs_IF_ID       (rs_IF_ID),
        .rt_IF_ID       (rt_IF_ID),
        .tuse_rs_ID     (tuse_rs_ID),
        .tuse_rt_ID     (tuse_rt_ID),
        .md_use_ID      (md_use_ID),
        .rd_ID_EX       (rd_ID_EX),
        .we_ID_EX       (we_ID_EX),
        .tnew_ID_EX     (tnew_ID_EX),
        .rd_EX_MEM      (rd_EX_MEM),
        .we_EX_MEM      (we_EX_MEM),
        .tnew_EX_MEM    (tnew_EX_MEM),
        .rd_MEM_WB      (rd_MEM_WB),
        .we_MEM_WB      (we_MEM_WB),
        .md_start_ID_EX (md_start_ID_EX),
        .md_div_ID_EX   (md_div_ID_EX),
        .stall          (stall),
        .flush_ID_EX    (flush_ID_EX),
        .md_busy        (md_busy),
        .fwd_rs_ID      (fwd_rs_ID),
        .fwd_rt_ID      (fwd_rt_ID),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the unit is busy until an absolute edge number; the counter is just a
    // saturating integer.
    longint ecnt     = 0;
    longint busy_end = 0;
    int     m_cnt    = 0;

    function automatic bit m_match(input bit we, input int rd, input int src);
        return we && (rd != 0) && (rd == src);
    endfunction

    function automatic bit m_src_stall(input int src, input int tuse);
        if (tuse == 3) return 1'b0;
        return (m_match(we_ID_EX, int'(rd_ID_EX), src) && int'(tnew_ID_EX) > tuse) ||
               (m_match(we_EX_MEM, int'(rd_EX_MEM), src) && int'(tnew_EX_MEM) > tuse);
    endfunction

    function automatic bit m_busy();
        return md_start_ID_EX || (ecnt < busy_end);
    endfunction

    function automatic bit m_stall();
        return m_src_stall(int'(rs_IF_ID), int'(tuse_rs_ID)) ||
               m_src_stall(int'(rt_IF_ID), int'(tuse_rt_ID)) ||
               (md_use_ID && m_busy());
    endfunction

    function automatic int m_fwd(input int src);
        if (m_match(we_EX_MEM, int'(rd_EX_MEM), src) && tnew_EX_MEM == 2'd0) return 2;
        if (m_match(we_MEM_WB, int'(rd_MEM_WB), src)) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_end = 0;
            m_cnt    = 0;
        end else begin
            if (m_stall()) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            // Issue accepted only when the unit is idle; busy for the next n cycles after this edge.
            if (md_start_ID_EX && ecnt >= busy_end)
                busy_end = ecnt + 1 + (md_div_ID_EX ? DC : MC);
            ecnt++;
        end
    end

    always @(negedge clk) begin
        chk("stall", 32'(stall), 32'(m_stall()));
        chk("flush", 32'(flush_ID_EX), 32'(m_stall()));
        chk("md_busy", 32'(md_busy), 32'(m_busy()));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (!m_stall()) begin
            chk("fwd_rs", 32'(fwd_rs_ID), 32'(m_fwd(int'(rs_IF_ID))));
            chk("fwd_rt", 32'(fwd_rt_ID), 32'(m_fwd(int'(rt_IF_ID))));
        end
    end

    task automatic clear_in();
        rs_IF_ID = 0; rt_IF_ID = 0; tuse_rs_ID = 2'd3; tuse_rt_ID = 2'd3; md_use_ID = 0;
        rd_ID_EX = 0; we_ID_EX = 0; tnew_ID_EX = 0;
        rd_EX_MEM = 0; we_EX_MEM = 0; tnew_EX_MEM = 0;
        rd_MEM_WB = 0; we_MEM_WB = 0;
        md_start_ID_EX = 0; md_div_ID_EX = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_in();
        rst_n = 1'b0;
        #2;
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Load-use: lw $2 in EX, add uses $2 in EX stage.
        clear_in();
        rs_IF_ID = 5'd2; tuse_rs_ID = 2'd1; rd_ID_EX = 5'd2; we_ID_EX = 1; tnew_ID_EX = 2'd2;
        #1;
        chk("lw_use_stall", 32'(stall), 32'd1);
        chk("lw_use_flush", 32'(flush_ID_EX), 32'd1);
        step();
        rd_ID_EX = 0; we_ID_EX = 0; tnew_ID_EX = 0;
        rd_EX_MEM = 5'd2; we_EX_MEM = 1; tnew_EX_MEM = 2'd1;
        #1;
        chk("lw_mem_stall", 32'(stall), 32'd0);
        chk("lw_mem_fwd", 32'(fwd_rs_ID), 32'd0);
        step();

        // Branch compare: add $3 in EX then MEM.
        clear_in();
        rs_IF_ID = 5'd3; tuse_rs_ID = 2'd0; rd_ID_EX = 5'd3; we_ID_EX = 1; tnew_ID_EX = 2'd1;
        #1;
        chk("beq_ex_stall", 32'(stall), 32'd1);
        step();
        rd_ID_EX = 0; we_ID_EX = 0; tnew_ID_EX = 0;
        rd_EX_MEM = 5'd3; we_EX_MEM = 1; tnew_EX_MEM = 2'd0;
        #1;
        chk("beq_mem_stall", 32'(stall), 32'd0);
        chk("beq_mem_fwd", 32'(fwd_rs_ID), 32'd2);
        step();

        // $0 never matches.
        clear_in();
        rs_IF_ID = 5'd0; tuse_rs_ID = 2'd0; rd_ID_EX = 5'd0; we_ID_EX = 1; tnew_ID_EX = 2'd2;
        rd_EX_MEM = 5'd0; we_EX_MEM = 1; rd_MEM_WB = 5'd0; we_MEM_WB = 1;
        #1;
        chk("r0_stall", 32'(stall), 32'd0);
        chk("r0_fwd", 32'(fwd_rs_ID), 32'd0);
        step();

        // MEM wins over WB; WB alone gives 1.
        clear_in();
        rt_IF_ID = 5'd4; tuse_rt_ID = 2'd0;
        rd_EX_MEM = 5'd4; we_EX_MEM = 1; tnew_EX_MEM = 2'd0; rd_MEM_WB = 5'd4; we_MEM_WB = 1;
        #1;
        chk("fwd_prio", 32'(fwd_rt_ID), 32'd2);
        step();
        we_EX_MEM = 0;
        #1;
        chk("fwd_wb", 32'(fwd_rt_ID), 32'd1);
        step();

        // div with mflo waiting in ID.
        clear_in();
        do_reset();
        md_start_ID_EX = 1; md_div_ID_EX = 1;
        #1;
        chk("div_issue_busy", 32'(md_busy), 32'd1);
        step();
        md_start_ID_EX = 0; md_div_ID_EX = 0; md_use_ID = 1;
        for (int i = 0; i < DC; i++) begin
            #1;
            chk("div_window_stall", 32'(stall), 32'd1);
            step();
        end
        #1;
        chk("div_end_stall", 32'(stall), 32'd0);
        chk("div_end_busy", 32'(md_busy), 32'd0);
        chk("div_stall_cnt", 32'(stall_cnt), 32'd10);
        step();

        // Reset during a mult window.
        clear_in();
        md_start_ID_EX = 1;
        step();
        md_start_ID_EX = 0; md_use_ID = 1;
        step();
        step();
        #1;
        chk("mult_mid_busy", 32'(md_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(md_busy), 32'd0);
        chk("async_rst_cnt", 32'(stall_cnt), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Counter saturation with a held register hazard.
        clear_in();
        rs_IF_ID = 5'd7; tuse_rs_ID = 2'd0; rd_ID_EX = 5'd7; we_ID_EX = 1; tnew_ID_EX = 2'd2;
        for (int i = 0; i < CMAX + 8; i++) step();
        chk("sat_cnt", 32'(stall_cnt), 32'(CMAX));
        clear_in();
        step();

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            rs_IF_ID       = 5'($urandom_range(0, 7));
            rt_IF_ID       = 5'($urandom_range(0, 7));
            tuse_rs_ID     = 2'($urandom_range(0, 3));
            tuse_rt_ID     = 2'($urandom_range(0, 3));
            md_use_ID      = ($urandom_range(0, 2) == 0);
            rd_ID_EX       = 5'($urandom_range(0, 7));
            we_ID_EX       = 1'($urandom_range(0, 1));
            tnew_ID_EX     = 2'($urandom_range(0, 2));
            rd_EX_MEM      = 5'($urandom_range(0, 7));
            we_EX_MEM      = 1'($urandom_range(0, 1));
            tnew_EX_MEM    = 2'($urandom_range(0, 1));
            rd_MEM_WB      = 5'($urandom_range(0, 7));
            we_MEM_WB      = 1'($urandom_range(0, 1));
            md_start_ID_EX = ($urandom_range(0, 5) == 0);
            md_div_ID_EX   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
